// File: rtl/multicycle_alu_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_alu_pkg
// Purpose : shared definitions for the multi-cycle execute-stage ALU.
//           OP code values as driven by the ALU control decoder, the FSM state
//           encoding, and a helper that classifies iterative ops.
// Ports   : none (package)
// Config  : none
// -----------------------------------------------------------------------------
package multicycle_alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_DIV = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    // True for ops that take WIDTH iterations instead of one cycle.
    function automatic logic is_multicycle(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/multicycle_alu_if.sv
// -----------------------------------------------------------------------------
// multicycle_alu_if
// Purpose : bundles the ALU operand/command and result/status signals.
// Signals : start, op, a, b          (master -> slave)
//           result, zero, busy, done, div_zero, ovf (slave -> master)
// Config  : ALU_OVF_EN adds the ovf signal; absent otherwise.
//
// Handshake: the master raises start with op/a/b valid. The slave accepts the
// command on any rising edge where start=1 and busy=0; a/b are captured at that
// edge and may change afterwards. While busy=1, start is ignored. Completion is
// signalled by a single-cycle done pulse; result/zero/div_zero(/ovf) are valid
// from that cycle and are held until the next completion. A new command may be
// presented in the same cycle that done is high.
// -----------------------------------------------------------------------------
interface multicycle_alu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             busy;
    logic             done;
    logic             div_zero;
`ifdef ALU_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, op, a, b,
        input  result, zero, busy, done, div_zero
`ifdef ALU_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  start, op, a, b,
        output result, zero, busy, done, div_zero
`ifdef ALU_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/multicycle_alu_muldiv_iter.sv
// -----------------------------------------------------------------------------
// muldiv_iter
// Purpose : shared iterative datapath for unsigned shift-add multiply and
//           unsigned restoring divide. One iteration per i_step edge; WIDTH
//           iterations give the full answer.
// Ports   : i_clk, i_rst_n  clock, synchronous active-low reset
//           i_load          capture operands (acc cleared, q=A, m=B)
//           i_step          perform one iteration
//           i_is_div        iteration kind: 1 = divide, 0 = multiply
//           i_a, i_b        operands
//           o_result        value the result register will hold after this
//                           step (product low bits or quotient)
// Config  : none
// -----------------------------------------------------------------------------
module muldiv_iter
#(
    parameter int WIDTH = 32
)
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result
);

    // r_acc: product accumulator (mul) / partial remainder (div)
    // r_q  : multiplier shifted right (mul) / dividend->quotient (div)
    // r_m  : multiplicand shifted left (mul) / fixed divisor (div)
    logic [WIDTH-1:0] r_acc, r_q, r_m;
    logic [WIDTH-1:0] w_acc_nxt, w_q_nxt, w_m_nxt;
    logic [WIDTH:0]   w_shift, w_trial;

    always_comb begin
        // Remainder shifted left with the next dividend bit; WIDTH+1 bits so the
        // trial subtraction's borrow lands in the top bit.
        w_shift   = {r_acc, r_q[WIDTH-1]};
        w_trial   = w_shift - {1'b0, r_m};
        w_acc_nxt = r_acc;
        w_q_nxt   = r_q;
        w_m_nxt   = r_m;
        if (i_is_div) begin
            if (!w_trial[WIDTH]) begin
                w_acc_nxt = w_trial[WIDTH-1:0];
                w_q_nxt   = {r_q[WIDTH-2:0], 1'b1};
            end else begin
                // Restore: shifted remainder is below the divisor, fits WIDTH.
                w_acc_nxt = w_shift[WIDTH-1:0];
                w_q_nxt   = {r_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            w_acc_nxt = r_q[0] ? (r_acc + r_m) : r_acc;
            w_q_nxt   = r_q >> 1;
            w_m_nxt   = r_m << 1;
        end
        o_result = i_is_div ? w_q_nxt : w_acc_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_acc <= '0;
            r_q   <= '0;
            r_m   <= '0;
        end else if (i_load) begin
            r_acc <= '0;
            r_q   <= i_a;
            r_m   <= i_b;
        end else if (i_step) begin
            r_acc <= w_acc_nxt;
            r_q   <= w_q_nxt;
            r_m   <= w_m_nxt;
        end
    end

endmodule

// File: rtl/multicycle_alu.sv
// -----------------------------------------------------------------------------
// multicycle_alu
// Purpose : execute-stage ALU. add/sub/and/or/slt/nop complete in one cycle;
//           mul/div iterate for WIDTH cycles with busy asserted. Holds the
//           control FSM, the one-cycle datapath and the output registers.
// Ports   : i_clk        clock, all state on rising edge
//           i_rst_n      synchronous active-low reset
//           bus          multicycle_alu_if.slave (start/op/a/b in,
//                        result/zero/busy/done/div_zero[/ovf] out)
//           o_dbg_state  current FSM state
// Config  : ALU_OVF_EN  - when defined, signed overflow of add/sub is reported
//                         on bus.ovf; otherwise that logic is not built.
// -----------------------------------------------------------------------------
module multicycle_alu
    import multicycle_alu_pkg::*;
#(
    parameter int WIDTH = 32
)
(
    input  logic           i_clk,
    input  logic           i_rst_n,
    multicycle_alu_if.slave bus,
    output state_t         o_dbg_state
);

    localparam int CW = $clog2(WIDTH);

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_result;
    logic             r_zero, r_done, r_div_zero, r_b_zero;
    logic             w_accept, w_load, w_step, w_finish, w_single;
    logic [WIDTH-1:0] w_alu_result, w_md_result, w_md_final;

    // ---------------- one-cycle datapath ----------------
    always_comb begin
        w_alu_result = '0;
        case (bus.op)
            OP_ADD:  w_alu_result = bus.a + bus.b;
            OP_SUB:  w_alu_result = bus.a - bus.b;
            OP_AND:  w_alu_result = bus.a & bus.b;
            OP_OR:   w_alu_result = bus.a | bus.b;
            OP_SLT:  w_alu_result = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            default: w_alu_result = '0;
        endcase
    end

`ifdef ALU_OVF_EN
    logic r_ovf, w_alu_ovf;
    // Overflow when operands (B inverted for sub) share a sign the result lacks.
    always_comb begin
        w_alu_ovf = 1'b0;
        if (bus.op == OP_ADD)
            w_alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                        (w_alu_result[WIDTH-1] != bus.a[WIDTH-1]);
        else if (bus.op == OP_SUB)
            w_alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                        (w_alu_result[WIDTH-1] != bus.a[WIDTH-1]);
    end
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_load      = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept = 1'b1;
                    if (is_multicycle(bus.op)) begin
                        w_load      = 1'b1;
                        w_cnt_nxt   = CW'(WIDTH - 1);
                        w_state_nxt = (bus.op == OP_MUL) ? S_MUL : S_DIV;
                    end
                end
            end
            S_MUL, S_DIV: begin
                w_step = 1'b1;
                if (r_cnt == '0) w_state_nxt = S_IDLE;
                else             w_cnt_nxt   = r_cnt - 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_single = w_accept && !is_multicycle(bus.op);
    assign w_finish = w_step && (r_cnt == '0);

    muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_load   (w_load),
        .i_step   (w_step),
        .i_is_div (r_state == S_DIV),
        .i_a      (bus.a),
        .i_b      (bus.b),
        .o_result (w_md_result)
    );

    // Divide by zero forces all-ones regardless of what the iterations produce.
    assign w_md_final = ((r_state == S_DIV) && r_b_zero) ? '1 : w_md_result;

    // ---------------- output registers ----------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_result   <= '0;
            r_zero     <= 1'b1;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            r_b_zero   <= 1'b0;
`ifdef ALU_OVF_EN
            r_ovf      <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (w_load) r_b_zero <= (bus.b == '0);
            if (w_single) begin
                r_done     <= 1'b1;
                r_div_zero <= 1'b0;
                // nop completes but leaves result/zero alone.
                if (bus.op != OP_NOP) begin
                    r_result <= w_alu_result;
                    r_zero   <= (w_alu_result == '0);
                end
`ifdef ALU_OVF_EN
                r_ovf <= w_alu_ovf;
`endif
            end else if (w_finish) begin
                r_done     <= 1'b1;
                r_result   <= w_md_final;
                r_zero     <= (w_md_final == '0);
                r_div_zero <= (r_state == S_DIV) && r_b_zero;
`ifdef ALU_OVF_EN
                r_ovf <= 1'b0;
`endif
            end
        end
    end

    assign bus.result   = r_result;
    assign bus.zero     = r_zero;
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.done     = r_done;
    assign bus.div_zero = r_div_zero;
`ifdef ALU_OVF_EN
    assign bus.ovf      = r_ovf;
`endif
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_multicycle_alu.sv
// -----------------------------------------------------------------------------
// tb_multicycle_alu
// Purpose : self-checking bench for multicycle_alu (WIDTH=32). Directed vector
//           table, randomized ops against an arithmetic reference model, and
//           hand-written multi-cycle corner sequences.
// Config  : honours ALU_OVF_EN (ovf checks compiled only when defined).
// -----------------------------------------------------------------------------
module tb_multicycle_alu;
    import multicycle_alu_pkg::*;

    localparam int W = 32;

    // ---------------- clock / reset ----------------
    logic   clk = 1'b0;
    logic   rst_n;
    state_t dbg_state;

    always #5 clk = ~clk;

    multicycle_alu_if #(.WIDTH(W)) bus ();

    multicycle_alu #(.WIDTH(W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .bus         (bus.slave),
        .o_dbg_state (dbg_state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: what the ALU's held outputs should be right now.
    logic [W-1:0] m_result;
    logic         m_div_zero;
    logic         m_ovf;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_res;
        logic         exp_zero;
        logic         exp_dz;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] ref_result(input logic [2:0] op, input logic [W-1:0] a,
                                                input logic [W-1:0] b, input logic [W-1:0] prev);
        longint unsigned prod;
        case (op)
            OP_ADD: return a + b;
            OP_SUB: return a - b;
            OP_AND: return a & b;
            OP_OR:  return a | b;
            OP_SLT: return ($signed(a) < $signed(b)) ? 1 : 0;
            OP_MUL: begin
                prod = longint'(a) * longint'(b);
                return prod[W-1:0];
            end
            OP_DIV: return (b == 0) ? {W{1'b1}} : a / b;
            default: return prev;
        endcase
    endfunction

    function automatic logic ref_ovf(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint s;
        if (op == OP_ADD)      s = longint'($signed(a)) + longint'($signed(b));
        else if (op == OP_SUB) s = longint'($signed(a)) - longint'($signed(b));
        else                   return 1'b0;
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    // ---------------- driver ----------------
    // Issues one op from idle, waits (bounded) for done, checks latency, busy
    // duration and all status outputs, then one more cycle for done falling.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_res, input logic exp_zero,
                          input logic exp_dz, input logic exp_ovf);
        int lat;
        int busy_n;
        logic multi;
        multi = (op == OP_MUL) || (op == OP_DIV);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        tick();
        bus.start = 1'b0;
        bus.a = $urandom; bus.b = $urandom;  // must not disturb the running op
        lat = 0; busy_n = 0;
        while (!bus.done && lat < 100) begin
            if (bus.busy) busy_n++;
            tick();
            lat++;
        end
        check("latency",     lat,          multi ? W : 0);
        check("busy_cycles", busy_n,       multi ? W : 0);
        check("busy_at_done", bus.busy,    1'b0);
        check("result",      bus.result,   exp_res);
        check("zero",        bus.zero,     exp_zero);
        check("div_zero",    bus.div_zero, exp_dz);
`ifdef ALU_OVF_EN
        check("ovf",         bus.ovf,      exp_ovf);
`endif
        m_result = exp_res; m_div_zero = exp_dz; m_ovf = exp_ovf;
        tick();
        check("done_pulse", bus.done, 1'b0);
    endtask

    task automatic run_random(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        r = ref_result(op, a, b, m_result);
        run_op(op, a, b, r, (r == 0), (op == OP_DIV) && (b == 0), ref_ovf(op, a, b));
    endtask

    task automatic add_vec(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] r, input logic z, input logic dz, input logic ov);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.exp_res = r; v.exp_zero = z; v.exp_dz = dz; v.exp_ovf = ov;
        vecs.push_back(v);
    endtask

    initial begin
        int lat;
        int seen_done;
        logic [2:0] rop;
        logic [W-1:0] ra, rb;

        bus.start = 1'b0; bus.op = OP_NOP; bus.a = '0; bus.b = '0;

        // ---------------- reset ----------------
        rst_n = 1'b0;
        tick();
        check("rst_result",   bus.result,   '0);
        check("rst_zero",     bus.zero,     1'b1);
        check("rst_busy",     bus.busy,     1'b0);
        check("rst_done",     bus.done,     1'b0);
        check("rst_div_zero", bus.div_zero, 1'b0);
`ifdef ALU_OVF_EN
        check("rst_ovf",      bus.ovf,      1'b0);
`endif
        rst_n = 1'b1;
        m_result = '0; m_div_zero = 1'b0; m_ovf = 1'b0;
        tick();

        // ---------------- directed table ----------------
        add_vec(OP_ADD, 5, 7, 12, 0, 0, 0);
        add_vec(OP_SUB, 5, 7, 32'hFFFF_FFFE, 0, 0, 0);
        add_vec(OP_SLT, 5, 7, 1, 0, 0, 0);
        add_vec(OP_SUB, 3, 3, 0, 1, 0, 0);
        add_vec(OP_NOP, 9, 9, 0, 1, 0, 0);
        add_vec(OP_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 0, 0, 0);
        add_vec(OP_OR,  32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF, 0, 0, 0);
        add_vec(OP_SLT, 32'hFFFF_FFFF, 1, 1, 0, 0, 0);
        add_vec(OP_SLT, 1, 32'hFFFF_FFFF, 0, 1, 0, 0);
        add_vec(OP_MUL, 1234, 5678, 32'd7006652, 0, 0, 0);
        add_vec(OP_DIV, 100, 7, 14, 0, 0, 0);
        add_vec(OP_DIV, 9, 0, 32'hFFFF_FFFF, 0, 1, 0);
        add_vec(OP_ADD, 2, 2, 4, 0, 0, 0);
        add_vec(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 0, 0);
        add_vec(OP_DIV, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 0, 0, 0);
        add_vec(OP_DIV, 6, 7, 0, 1, 0, 0);
        add_vec(OP_ADD, 32'h7FFF_FFFF, 1, 32'h8000_0000, 0, 0, 1);
        add_vec(OP_NOP, 0, 0, 32'h8000_0000, 0, 0, 0);
        add_vec(OP_SUB, 32'h8000_0000, 1, 32'h7FFF_FFFF, 0, 0, 1);
        add_vec(OP_ADD, 2, 2, 4, 0, 0, 0);

        foreach (vecs[i])
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_res,
                   vecs[i].exp_zero, vecs[i].exp_dz, vecs[i].exp_ovf);

        // ---------------- randomized against model ----------------
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            if (rop == OP_DIV) rb = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(1, 1000));
            if ($urandom_range(0, 5) == 0) rb = ra;
            run_random(rop, ra, rb);
        end

        // ---------------- START during mul is ignored ----------------
        bus.start = 1'b1; bus.op = OP_MUL; bus.a = 1234; bus.b = 5678;
        tick();
        lat = 0;
        bus.start = 1'b0;
        repeat (5) begin tick(); lat++; end
        bus.start = 1'b1; bus.op = OP_ADD; bus.a = 1; bus.b = 1;
        repeat (3) begin tick(); lat++; end
        bus.start = 1'b0;
        while (!bus.done && lat < 100) begin tick(); lat++; end
        check("midmul_latency", lat, W);
        check("midmul_result", bus.result, 32'd7006652);
        tick();
        check("midmul_idle", bus.busy, 1'b0);

        // ---------------- START accepted on DONE cycle ----------------
        bus.start = 1'b1; bus.op = OP_DIV; bus.a = 100; bus.b = 7;
        tick();
        bus.start = 1'b0;
        lat = 0;
        while (!bus.done && lat < 100) begin tick(); lat++; end
        check("b2b_div_result", bus.result, 14);
        bus.start = 1'b1; bus.op = OP_ADD; bus.a = 2; bus.b = 3;
        tick();
        bus.start = 1'b0;
        check("b2b_add_done",   bus.done,   1'b1);
        check("b2b_add_result", bus.result, 5);
        check("b2b_add_busy",   bus.busy,   1'b0);
        tick();
        check("b2b_done_low",   bus.done,   1'b0);

        // ---------------- reset in the middle of a mul ----------------
        bus.start = 1'b1; bus.op = OP_MUL; bus.a = 1234; bus.b = 5678;
        tick();
        bus.start = 1'b0;
        repeat (10) tick();
        check("abort_busy_before", bus.busy, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_busy",   bus.busy,   1'b0);
        check("abort_done",   bus.done,   1'b0);
        check("abort_result", bus.result, '0);
        check("abort_zero",   bus.zero,   1'b1);
        seen_done = 0;
        repeat (40) begin
            tick();
            if (bus.done) seen_done++;
        end
        check("abort_no_done", seen_done, 0);
        m_result = '0; m_div_zero = 1'b0; m_ovf = 1'b0;

        // One more op after the abort to confirm a clean restart.
        run_random(OP_MUL, 3, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
